// File: rtl/memory_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encodings,
// port-index sizing and response-ID ownership helpers.
`timescale 1ns/1ps
package memory_bus_arbiter_pkg;

    // Request-path output register states (state value doubles as msValid)
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    // Width of an index that can address num_ports ports (at least 1 bit)
    function automatic int port_idx_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    // A response ID offset (smID - ID_BASE, already sign-correct) maps to an
    // upstream port only when it lands inside [0, num_ports)
    function automatic logic port_offset_owned(input int offset, input int num_ports);
        return (offset >= 0) && (offset < num_ports);
    endfunction

endpackage

// File: rtl/memory_bus_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans requests starting one past the last granted
// port, wrapping at N-1, and returns a one-hot grant plus its index.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    int   scan_idx;
    logic found;

    // Pick the first requesting port in rotated priority order
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        scan_idx    = 0;
        for (int k = 1; k <= N; k++) begin
            scan_idx = int'(last_grant_i) + k;
            if (scan_idx >= N) begin
                scan_idx = scan_idx - N;
            end
            if (!found && req_i[scan_idx]) begin
                found             = 1'b1;
                grant_o[scan_idx] = 1'b1;
                grant_idx_o       = IDX_W'(scan_idx);
            end
        end
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Memory bus arbiter: N upstream requesters share one registered downstream
// request slot (round-robin, zero-bubble); downstream responses are routed
// back combinationally by transaction ID.
`timescale 1ns/1ps
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH      = 24,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int MASTER_ID_WIDTH = 8,
    parameter int NUM_PORTS       = 4,
    parameter int ID_BASE         = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_PORTS*MASTER_ID_WIDTH-1:0] upID,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0]   upAddress,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]      upData,
    input  logic [NUM_PORTS-1:0]                 upWrite,
    input  logic [NUM_PORTS-1:0]                 upValid,
    output logic [NUM_PORTS-1:0]                 upTaken,
    output logic [DATA_WIDTH-1:0]                upRspData,
    output logic [NUM_PORTS-1:0]                 upRspValid,
    input  logic [NUM_PORTS-1:0]                 upRspTaken,
    output logic [MASTER_ID_WIDTH-1:0]           msID,
    output logic [ADDRESS_WIDTH-1:0]             msAddress,
    output logic [DATA_WIDTH-1:0]                msData,
    output logic                                 msWrite,
    output logic                                 msValid,
    input  logic                                 msTaken,
    input  logic [MASTER_ID_WIDTH-1:0]           smID,
    input  logic [DATA_WIDTH-1:0]                smData,
    input  logic                                 smValid,
    output logic                                 smTaken,
    output logic                                 idError
);

    localparam int IDX_W    = port_idx_width(NUM_PORTS);
    localparam int ID_EXT_W = MASTER_ID_WIDTH + 1;
    localparam logic [ID_EXT_W-1:0] ID_BASE_EXT = ID_EXT_W'(ID_BASE);
    localparam logic [IDX_W-1:0]    LAST_RESET  = IDX_W'(NUM_PORTS - 1);

    // Request path state
    logic                       state_q, state_d;
    logic [IDX_W-1:0]           last_grant_q, last_grant_d;
    logic [MASTER_ID_WIDTH-1:0] ms_id_q, ms_id_d;
    logic [ADDRESS_WIDTH-1:0]   ms_addr_q, ms_addr_d;
    logic [DATA_WIDTH-1:0]      ms_data_q, ms_data_d;
    logic                       ms_write_q, ms_write_d;
    logic                       id_error_q, id_error_d;

    logic                       loadable;
    logic                       load;
    logic [NUM_PORTS-1:0]       grant;
    logic [IDX_W-1:0]           grant_idx;
    logic [MASTER_ID_WIDTH-1:0] sel_id;
    logic [ADDRESS_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]      sel_data;
    logic                       sel_write;

    // Response path
    logic signed [ID_EXT_W-1:0] rsp_offset;
    logic                       rsp_owned;
    logic [IDX_W-1:0]           rsp_port;

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req_i        (upValid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    // Slot accepts a new request when empty or being drained this cycle;
    // nothing is accepted while reset is held low
    assign loadable = (state_q == ST_EMPTY) || msTaken;
    assign load     = loadable && (|upValid) && reset;
    assign upTaken  = load ? grant : '0;

    // Select the granted port's request fields (grant is one-hot)
    always_comb begin
        sel_id    = '0;
        sel_addr  = '0;
        sel_data  = '0;
        sel_write = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) begin
                sel_id    = upID[p*MASTER_ID_WIDTH +: MASTER_ID_WIDTH];
                sel_addr  = upAddress[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_data  = upData[p*DATA_WIDTH +: DATA_WIDTH];
                sel_write = upWrite[p];
            end
        end
    end

    // EMPTY/FULL slot control: load, drain to empty, or hold stable
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ms_id_d      = ms_id_q;
        ms_addr_d    = ms_addr_q;
        ms_data_d    = ms_data_q;
        ms_write_d   = ms_write_q;
        if (load) begin
            state_d      = ST_FULL;
            last_grant_d = grant_idx;
            ms_id_d      = sel_id;
            ms_addr_d    = sel_addr;
            ms_data_d    = sel_data;
            ms_write_d   = sel_write;
        end else if ((state_q == ST_FULL) && msTaken) begin
            state_d = ST_EMPTY;
        end
    end

    // Register update; reset drops any held request and re-arms port 0 first
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_EMPTY;
            last_grant_q <= LAST_RESET;
            ms_id_q      <= '0;
            ms_addr_q    <= '0;
            ms_data_q    <= '0;
            ms_write_q   <= 1'b0;
            id_error_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ms_id_q      <= ms_id_d;
            ms_addr_q    <= ms_addr_d;
            ms_data_q    <= ms_data_d;
            ms_write_q   <= ms_write_d;
            id_error_q   <= id_error_d;
        end
    end

    assign msValid   = (state_q == ST_FULL);
    assign msID      = ms_id_q;
    assign msAddress = ms_addr_q;
    assign msData    = ms_data_q;
    assign msWrite   = ms_write_q;

    // One extra bit keeps IDs below ID_BASE negative instead of wrapping
    assign rsp_offset = {1'b0, smID} - ID_BASE_EXT;
    assign rsp_owned  = port_offset_owned(int'($signed(rsp_offset)), NUM_PORTS);
    assign rsp_port   = rsp_offset[IDX_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rsp_valid
            assign upRspValid[gi] = smValid && rsp_owned && (rsp_port == IDX_W'(gi));
        end
    endgenerate

    // Unowned responses are swallowed so the downstream never stalls on them
    assign smTaken   = rsp_owned ? upRspTaken[rsp_port] : 1'b1;
    assign upRspData = smData;

    // Sticky flag for any response carrying an ID no port owns
    always_comb begin
        id_error_d = id_error_q;
        if (smValid && !rsp_owned) begin
            id_error_d = 1'b1;
        end
    end

    assign idError = id_error_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
`timescale 1ns/1ps
module tb_memory_bus_arbiter;

    localparam int DW  = 24;
    localparam int AW  = 32;
    localparam int IW  = 8;
    localparam int NP  = 4;
    localparam int IDB = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [NP*IW-1:0]   upID = '0;
    logic [NP*AW-1:0]   upAddress = '0;
    logic [NP*DW-1:0]   upData = '0;
    logic [NP-1:0]      upWrite = '0;
    logic [NP-1:0]      upValid = '0;
    logic [NP-1:0]      upTaken;
    logic [DW-1:0]      upRspData;
    logic [NP-1:0]      upRspValid;
    logic [NP-1:0]      upRspTaken = '0;
    logic [IW-1:0]      msID;
    logic [AW-1:0]      msAddress;
    logic [DW-1:0]      msData;
    logic               msWrite;
    logic               msValid;
    logic               msTaken = 1'b0;
    logic [IW-1:0]      smID = '0;
    logic [DW-1:0]      smData = '0;
    logic               smValid = 1'b0;
    logic               smTaken;
    logic               idError;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          wr;
    } req_t;

    req_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    memory_bus_arbiter #(
        .DATA_WIDTH      (DW),
        .ADDRESS_WIDTH   (AW),
        .MASTER_ID_WIDTH (IW),
        .NUM_PORTS       (NP),
        .ID_BASE         (IDB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .upID       (upID),
        .upAddress  (upAddress),
        .upData     (upData),
        .upWrite    (upWrite),
        .upValid    (upValid),
        .upTaken    (upTaken),
        .upRspData  (upRspData),
        .upRspValid (upRspValid),
        .upRspTaken (upRspTaken),
        .msID       (msID),
        .msAddress  (msAddress),
        .msData     (msData),
        .msWrite    (msWrite),
        .msValid    (msValid),
        .msTaken    (msTaken),
        .smID       (smID),
        .smData     (smData),
        .smValid    (smValid),
        .smTaken    (smTaken),
        .idError    (idError)
    );

    always #5 clock = ~clock;

    function automatic int rr_pick(input logic [NP-1:0] v, input int last);
        for (int k = 1; k <= NP; k++) begin
            int idx;
            idx = (last + k) % NP;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic req_t port_req(input int p);
        req_t r;
        r.id   = upID[p*IW +: IW];
        r.addr = upAddress[p*AW +: AW];
        r.data = upData[p*DW +: DW];
        r.wr   = upWrite[p];
        return r;
    endfunction

    function automatic req_t dut_req();
        req_t r;
        r.id   = msID;
        r.addr = msAddress;
        r.data = msData;
        r.wr   = msWrite;
        return r;
    endfunction

    task automatic set_port(input int p, input logic [IW-1:0] id, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic w);
        upID[p*IW +: IW]      = id;
        upAddress[p*AW +: AW] = a;
        upData[p*DW +: DW]    = d;
        upWrite[p]            = w;
    endtask

    task automatic idle_inputs();
        upValid    = '0;
        msTaken    = 1'b0;
        smValid    = 1'b0;
        upRspTaken = '0;
    endtask

    task automatic test_reset();
        req_t z;
        z = '0;
        idle_inputs();
        reset   = 1'b0;
        upValid = '1;
        msTaken = 1'b1;
        @(negedge clock);
        #1;
        checks++;
        if (msValid !== 1'b0) begin failures++; $display("FAIL reset_msValid got=%b exp=0", msValid); end
        checks++;
        if (dut_req() !== z) begin failures++; $display("FAIL reset_fields got=%h exp=%h", dut_req(), z); end
        checks++;
        if (upTaken !== '0) begin failures++; $display("FAIL reset_upTaken got=%b exp=0000", upTaken); end
        checks++;
        if (idError !== 1'b0) begin failures++; $display("FAIL reset_idError got=%b exp=0", idError); end
        $display("reset: msValid=%b upTaken=%b idError=%b", msValid, upTaken, idError);
        @(negedge clock);
    endtask

    task automatic test_round_robin();
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        req_t e;
        logic [NP-1:0] exp_t;
        for (int p = 0; p < NP; p++) begin
            set_port(p, IW'(IDB + p), AW'(32'h1000 + p), DW'(24'h111 * (p + 1)), p[0]);
        end
        upValid = '1;
        msTaken = 1'b1;
        reset   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (msValid !== 1'b1) begin failures++; $display("FAIL rr_msValid cyc=%0d got=%b exp=1", i, msValid); end
                checks++;
                if (dut_req() !== e) begin failures++; $display("FAIL rr_emit cyc=%0d got=%h exp=%h", i, dut_req(), e); end
            end
            exp_t = '0;
            exp_t[seq[i]] = 1'b1;
            checks++;
            if (upTaken !== exp_t) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", i, upTaken, exp_t); end
            exp_q.push_back(port_req(seq[i]));
            $display("rr cyc=%0d upTaken=%b msValid=%b msAddress=%h", i, upTaken, msValid, msAddress);
            @(negedge clock);
        end
        upValid = '0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (dut_req() !== e) begin failures++; $display("FAIL rr_last_emit got=%h exp=%h", dut_req(), e); end
        @(negedge clock);
        #1;
        checks++;
        if (msValid !== 1'b0) begin failures++; $display("FAIL rr_drain_empty got=%b exp=0", msValid); end
        $display("rr drain: msValid=%b", msValid);
        @(negedge clock);
    endtask

    task automatic test_backpressure();
        req_t e;
        idle_inputs();
        set_port(2, 8'd6, 32'h10, 24'hABCDEF, 1'b1);
        upValid = 4'b0100;
        #1;
        checks++;
        if (upTaken !== 4'b0100) begin failures++; $display("FAIL bp_grant got=%b exp=0100", upTaken); end
        exp_q.push_back(port_req(2));
        @(negedge clock);
        set_port(2, 8'd6, 32'h20, 24'h123456, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            e = exp_q[0];
            checks++;
            if (upTaken !== '0) begin failures++; $display("FAIL bp_stall_taken cyc=%0d got=%b exp=0000", k, upTaken); end
            checks++;
            if (msValid !== 1'b1) begin failures++; $display("FAIL bp_stall_valid cyc=%0d got=%b exp=1", k, msValid); end
            checks++;
            if (dut_req() !== e) begin failures++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", k, dut_req(), e); end
            $display("bp stall cyc=%0d msAddress=%h msData=%h upTaken=%b", k, msAddress, msData, upTaken);
            @(negedge clock);
        end
        upValid = '0;
        msTaken = 1'b1;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (dut_req() !== e) begin failures++; $display("FAIL bp_transfer got=%h exp=%h", dut_req(), e); end
        @(negedge clock);
        #1;
        checks++;
        if (msValid !== 1'b0) begin failures++; $display("FAIL bp_after got=%b exp=0", msValid); end
        $display("bp transfer done: msValid=%b", msValid);
        @(negedge clock);
    endtask

    task automatic test_response_routing();
        logic [IW-1:0] ids[5]   = '{8'd6, 8'd6, 8'd4, 8'd7, 8'd5};
        logic [NP-1:0] rtk[5]   = '{4'b0100, 4'b0000, 4'b0001, 4'b1000, 4'b1101};
        logic [NP-1:0] evld[5]  = '{4'b0100, 4'b0100, 4'b0001, 4'b1000, 4'b0010};
        logic          etk[5]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            smID       = ids[i];
            smData     = DW'($urandom);
            smValid    = 1'b1;
            upRspTaken = rtk[i];
            #1;
            checks++;
            if (upRspValid !== evld[i]) begin failures++; $display("FAIL rsp_valid id=%0d got=%b exp=%b", smID, upRspValid, evld[i]); end
            checks++;
            if (smTaken !== etk[i]) begin failures++; $display("FAIL rsp_taken id=%0d got=%b exp=%b", smID, smTaken, etk[i]); end
            checks++;
            if (upRspData !== smData) begin failures++; $display("FAIL rsp_data id=%0d got=%h exp=%h", smID, upRspData, smData); end
            $display("rsp id=%0d upRspValid=%b smTaken=%b data=%h", smID, upRspValid, smTaken, upRspData);
            @(negedge clock);
        end
        smValid = 1'b0;
        #1;
        checks++;
        if (idError !== 1'b0) begin failures++; $display("FAIL rsp_no_error got=%b exp=0", idError); end
        @(negedge clock);
    endtask

    task automatic test_id_error();
        logic [IW-1:0] ids[4] = '{8'd3, 8'd9, 8'd255, 8'd0};
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            smID       = ids[i];
            smValid    = 1'b1;
            upRspTaken = '1;
            #1;
            checks++;
            if (smTaken !== 1'b1) begin failures++; $display("FAIL iderr_taken id=%0d got=%b exp=1", smID, smTaken); end
            checks++;
            if (upRspValid !== '0) begin failures++; $display("FAIL iderr_valid id=%0d got=%b exp=0000", smID, upRspValid); end
            if (i == 0) begin
                checks++;
                if (idError !== 1'b0) begin failures++; $display("FAIL iderr_early got=%b exp=0", idError); end
            end
            @(negedge clock);
            #1;
            checks++;
            if (idError !== 1'b1) begin failures++; $display("FAIL iderr_set id=%0d got=%b exp=1", smID, idError); end
            $display("iderr id=%0d smTaken=%b idError=%b", smID, smTaken, idError);
            @(negedge clock);
        end
        smValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (idError !== 1'b1) begin failures++; $display("FAIL iderr_sticky cyc=%0d got=%b exp=1", k, idError); end
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        set_port(3, 8'd7, 32'hDEAD0003, 24'h333333, 1'b1);
        upValid = 4'b1000;
        #1;
        checks++;
        if (upTaken !== 4'b1000) begin failures++; $display("FAIL rmid_grant got=%b exp=1000", upTaken); end
        @(negedge clock);
        upValid = '0;
        #1;
        checks++;
        if (msValid !== 1'b1) begin failures++; $display("FAIL rmid_full got=%b exp=1", msValid); end
        reset   = 1'b0;
        upValid = '1;
        #1;
        checks++;
        if (msValid !== 1'b0) begin failures++; $display("FAIL rmid_drop got=%b exp=0", msValid); end
        checks++;
        if (upTaken !== '0) begin failures++; $display("FAIL rmid_taken_in_reset got=%b exp=0000", upTaken); end
        $display("reset mid: msValid=%b upTaken=%b", msValid, upTaken);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (upTaken !== 4'b0001) begin failures++; $display("FAIL rmid_port0_first got=%b exp=0001", upTaken); end
        $display("reset release: upTaken=%b", upTaken);
        exp_q.delete();
        @(negedge clock);
    endtask

    task automatic test_random();
        logic          m_full;
        int            m_last;
        logic          m_err;
        int            wait_cnt[NP];
        int            g;
        int            off;
        logic          owned;
        logic [NP-1:0] exp_t;
        logic [NP-1:0] exp_rv;
        logic          exp_st;
        int            emitted;
        req_t          e;
        idle_inputs();
        reset = 1'b0;
        @(negedge clock);
        reset  = 1'b1;
        m_full = 1'b0;
        m_last = NP - 1;
        m_err  = 1'b0;
        emitted = 0;
        exp_q.delete();
        for (int p = 0; p < NP; p++) wait_cnt[p] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int p = 0; p < NP; p++) begin
                set_port(p, IW'(IDB + p), AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
            end
            upValid    = NP'($urandom);
            msTaken    = ($urandom_range(0, 3) != 0);
            smID       = IW'($urandom_range(2, 9));
            smData     = DW'($urandom);
            smValid    = 1'($urandom_range(0, 1));
            upRspTaken = NP'($urandom);
            #1;
            g = (!m_full || msTaken) ? rr_pick(upValid, m_last) : -1;
            exp_t = '0;
            if (g >= 0) exp_t[g] = 1'b1;
            checks++;
            if (upTaken !== exp_t) begin failures++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, upTaken, exp_t); end
            checks++;
            if (msValid !== m_full) begin failures++; $display("FAIL rnd_msValid cyc=%0d got=%b exp=%b", cyc, msValid, m_full); end
            if (m_full && msTaken) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_emit cyc=%0d got=%h exp=<none queued>", cyc, dut_req());
                end else begin
                    e = exp_q.pop_front();
                    if (dut_req() !== e) begin failures++; $display("FAIL rnd_emit cyc=%0d got=%h exp=%h", cyc, dut_req(), e); end
                end
                emitted++;
            end
            if (g >= 0) exp_q.push_back(port_req(g));
            off    = int'(smID) - IDB;
            owned  = (off >= 0) && (off < NP);
            exp_rv = '0;
            if (owned && smValid) exp_rv[off] = 1'b1;
            exp_st = owned ? upRspTaken[off] : 1'b1;
            checks++;
            if (upRspValid !== exp_rv) begin failures++; $display("FAIL rnd_rspvalid cyc=%0d got=%b exp=%b", cyc, upRspValid, exp_rv); end
            checks++;
            if (smTaken !== exp_st) begin failures++; $display("FAIL rnd_smTaken cyc=%0d got=%b exp=%b", cyc, smTaken, exp_st); end
            checks++;
            if (upRspData !== smData) begin failures++; $display("FAIL rnd_rspdata cyc=%0d got=%h exp=%h", cyc, upRspData, smData); end
            checks++;
            if (idError !== m_err) begin failures++; $display("FAIL rnd_idError cyc=%0d got=%b exp=%b", cyc, idError, m_err); end
            for (int p = 0; p < NP; p++) begin
                if (upTaken[p] || !upValid[p]) begin
                    wait_cnt[p] = 0;
                end else if (|upTaken) begin
                    wait_cnt[p]++;
                    checks++;
                    if (wait_cnt[p] > NP - 1) begin
                        failures++;
                        $display("FAIL rnd_starve cyc=%0d port=%0d got=%0d exp<=%0d", cyc, p, wait_cnt[p], NP - 1);
                    end
                end
            end
            if (cyc % 1000 == 0) begin
                $display("rnd cyc=%0d upValid=%b upTaken=%b msValid=%b msTaken=%b emitted=%0d", cyc, upValid, upTaken, msValid, msTaken, emitted);
            end
            if (g >= 0) begin
                m_full = 1'b1;
                m_last = g;
            end else if (msTaken) begin
                m_full = 1'b0;
            end
            if (smValid && !owned) m_err = 1'b1;
            @(negedge clock);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_response_routing();
        test_id_error();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
